imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// Boot-stream loader: parses a length-prefixed byte stream into 32-bit words,
// writes them to instruction memory and releases the CPU on a valid checksum.
module imem_loader #(
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 4096
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   output logic                  wren,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [31:0]           data,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);
   typedef enum logic [2:0] {HDR0, HDR1, DATA, WRITE, CHK, DONE, ERR} state_t;

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   state_t                state, state_next;
   logic [7:0]            n_hi;
   logic [7:0]            xor_acc;
   logic [15:0]           remaining;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            byte_cnt;
   logic [23:0]           partial;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [31:0]           data_r;
   logic                  accept;
   logic [15:0]           n_full;

   assign accept = rx_valid && rx_ready;
   assign n_full = {n_hi, rx_data};
   assign addr   = addr_r;
   assign data   = data_r;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clock) begin
      if (!reset) state <= HDR0;
      else        state <= state_next;
   end

   // NOTE: each combinational block assigns a default first; no path can
   // leave an output unassigned, so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         HDR0:  if (accept) state_next = HDR1;
         HDR1: begin
            if (accept) begin
               if (n_full == 16'd0)                 state_next = CHK;
               else if ({1'b0, n_full} > DEPTH_W)   state_next = ERR;
               else                                 state_next = DATA;
            end
         end
         DATA:  if (accept && byte_cnt == 2'd3) state_next = WRITE;
         WRITE: state_next = (remaining == 16'd1) ? CHK : DATA;
         CHK:   if (accept) state_next = (rx_data == xor_acc) ? DONE : ERR;
         DONE:  state_next = DONE;
         ERR:   state_next = ERR;
         default: state_next = HDR0;
      endcase
   end

   // Strobes are gated by reset so an abort in WRITE never emits a write.
   always_comb begin
      rx_ready = 1'b0;
      wren     = 1'b0;
      cpu_hold = 1'b1;
      done     = 1'b0;
      error    = 1'b0;
      case (state)
         HDR0, HDR1, DATA, CHK: rx_ready = reset;
         WRITE:                 wren     = reset;
         DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
         end
         ERR:                   error    = 1'b1;
         default: ;
      endcase
   end

   // addr/data are captured on the 4th byte so they stay stable after WRITE.
   always_ff @(posedge clock) begin
      if (!reset) begin
         n_hi      <= '0;
         xor_acc   <= '0;
         remaining <= '0;
         word_idx  <= '0;
         byte_cnt  <= '0;
         partial   <= '0;
         addr_r    <= '0;
         data_r    <= '0;
      end else begin
         if (accept) xor_acc <= xor_acc ^ rx_data;
         case (state)
            HDR0: if (accept) n_hi <= rx_data;
            HDR1: if (accept) remaining <= n_full;
            DATA: begin
               if (accept) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     addr_r <= word_idx;
                     data_r <= {partial, rx_data};
                  end else begin
                     partial <= {partial[15:0], rx_data};
                  end
               end
            end
            WRITE: begin
               word_idx  <= word_idx + ADDR_WIDTH'(1);
               remaining <= remaining - 16'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for imem_loader: a stream-level model predicts the writes
// and final status; a negedge monitor consumes writes as the DUT emits them.
module tb_imem_loader;
   localparam int ADDR_WIDTH = 12;
   localparam int DEPTH      = 4096;

   typedef logic [7:0] bytes_t[$];
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] a;
      logic [31:0]           d;
   } wr_t;

   logic                  clock    = 1'b0;
   logic                  reset    = 1'b0;
   logic                  rx_valid = 1'b0;
   logic [7:0]            rx_data  = 8'h00;
   logic                  rx_ready;
   logic                  wren;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           data;
   logic                  cpu_hold;
   logic                  done;
   logic                  error;

   int  checks    = 0;
   int  failures  = 0;
   wr_t exp_q[$];
   bit  in_stream = 1'b0;

   imem_loader #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
      .clock    (clock),
      .reset    (reset),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .wren     (wren),
      .addr     (addr),
      .data     (data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every write strobe must match the oldest predicted write.
   always @(negedge clock) begin
      wr_t e;
      if (in_stream) check("rx_ready_vs_wren", 32'(rx_ready), 32'(!wren));
      if (wren === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_wren: addr=0x%0h data=0x%0h with no write expected (t=%0t)",
                     addr, data, $time);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(addr), 32'(e.a));
            check("wr_data", data, e.d);
         end
      end
   end

   // Reference model: interpret a whole stream by the format rules.
   task automatic expect_stream(input bytes_t s, output bit e_done, output bit e_err);
      int         n;
      logic [7:0] x;
      wr_t        e;
      n      = int'({s[0], s[1]});
      x      = 8'h00;
      e_done = 1'b0;
      e_err  = 1'b0;
      if (n > DEPTH) begin
         e_err = 1'b1;
         return;
      end
      for (int w = 0; w < n; w++) begin
         e.a = ADDR_WIDTH'(w);
         e.d = {s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]};
         exp_q.push_back(e);
      end
      for (int i = 0; i < 2 + 4*n; i++) x ^= s[i];
      e_done = (s[2+4*n] == x);
      e_err  = !e_done;
   endtask

   task automatic build_stream(input int n, input bit bad, input bit incr, output bytes_t s);
      logic [7:0]  x;
      logic [31:0] w;
      s = {};
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      if (n > DEPTH) return;
      for (int i = 0; i < n; i++) begin
         w = incr ? 32'h1000_0000 + 32'(i) : $urandom;
         for (int k = 3; k >= 0; k--) s.push_back(w[8*k +: 8]);
      end
      x = 8'h00;
      foreach (s[i]) x ^= s[i];
      if (bad) x ^= 8'h01 << $urandom_range(7);
      s.push_back(x);
   endtask

   task automatic send_byte(input logic [7:0] b, input int pct, output bit ok);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 500) begin
         @(negedge clock);
         rx_valid = ($urandom_range(99) < pct);
         rx_data  = rx_valid ? b : 8'($urandom);
         #1 acc = rx_valid && rx_ready;
         @(posedge clock);
         n++;
      end
      ok = acc;
      if (!acc) check("accept_timeout", 32'(acc), 1);
   endtask

   task automatic send_stream(input bytes_t s, input int pct);
      bit e_done, e_err, ok;
      expect_stream(s, e_done, e_err);
      in_stream = 1'b1;
      ok        = 1'b1;
      foreach (s[i]) if (ok) send_byte(s[i], pct, ok);
      in_stream = 1'b0;
      @(negedge clock);
      rx_valid = 1'b0;
      check("done",     32'(done),     32'(e_done));
      check("error",    32'(error),    32'(e_err));
      check("cpu_hold", 32'(cpu_hold), 32'(!e_done));
      repeat (2) @(negedge clock);
      check("pending_writes", 32'(exp_q.size()), 0);
      check("done_sticky",    32'(done),         32'(e_done));
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset    = 1'b0;
      rx_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clock);
      check("rst_wren",     32'(wren),     0);
      check("rst_addr",     32'(addr),     0);
      check("rst_data",     data,          0);
      check("rst_rx_ready", 32'(rx_ready), 0);
      check("rst_cpu_hold", 32'(cpu_hold), 1);
      check("rst_done",     32'(done),     0);
      check("rst_error",    32'(error),    0);
      reset = 1'b1;
      @(negedge clock);
      check("ready_after_reset", 32'(rx_ready), 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] ref034 [11];
      bytes_t     s;
      bytes_t     bad;
      bit         ok;
      int         n;

      ref034 = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
                 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h21};
      s = {};
      foreach (ref034[i]) s.push_back(ref034[i]);
      bad = s;
      bad[10] = 8'h20;

      // Good and bad checksum on the reference stream.
      do_reset();
      send_stream(s, 100);
      do_reset();
      send_stream(bad, 100);

      // Empty image, and an oversized header.
      do_reset();
      build_stream(0, 1'b0, 1'b0, s);
      send_stream(s, 100);
      do_reset();
      build_stream(16'h1001, 1'b0, 1'b0, s);
      send_stream(s, 100);

      // Reference stream with random valid gaps, then bytes after DONE.
      s = {};
      foreach (ref034[i]) s.push_back(ref034[i]);
      do_reset();
      send_stream(s, 50);
      repeat (5) begin
         @(negedge clock);
         rx_valid = 1'b1;
         rx_data  = 8'($urandom);
         #1 check("ready_in_done", 32'(rx_ready), 0);
      end
      @(negedge clock);
      rx_valid = 1'b0;
      check("done_holds", 32'(done), 1);

      // Reset after two data bytes, then a full load from address 0.
      do_reset();
      send_byte(8'h00, 100, ok);
      send_byte(8'h02, 100, ok);
      send_byte(8'hA5, 100, ok);
      send_byte(8'h5A, 100, ok);
      do_reset();
      send_stream(s, 100);

      // Reset landing in the WRITE cycle must suppress the strobe.
      do_reset();
      send_byte(8'h00, 100, ok);
      send_byte(8'h01, 100, ok);
      send_byte(8'hAA, 100, ok);
      send_byte(8'hBB, 100, ok);
      send_byte(8'hCC, 100, ok);
      send_byte(8'hDD, 100, ok);
      #1 reset = 1'b0;
      @(negedge clock);
      check("wren_during_reset", 32'(wren), 0);
      do_reset();

      // Randomized streams of mixed kinds.
      for (int r = 0; r < 10; r++) begin
         case ($urandom_range(9))
            0:       n = 0;
            1:       n = $urandom_range(65535, DEPTH + 1);
            default: n = $urandom_range(8, 1);
         endcase
         build_stream(n, ($urandom_range(3) == 0), 1'b0, s);
         do_reset();
         send_stream(s, $urandom_range(100, 30));
      end

      // Full-depth image with incrementing words.
      build_stream(DEPTH, 1'b0, 1'b1, s);
      do_reset();
      send_stream(s, 100);
      check("last_addr", 32'(addr), 32'(DEPTH - 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
